// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson sequence controller.
// Holds the controller state encoding and the phase counter width function.
package johnson_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bits needed to count 0 .. 2*width-1.
  function automatic int PHASE_W(input int width);
    return (width < 1) ? 1 : $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_core.sv
// Johnson shift register with enable, synchronous clear and direction select.
// Holds no sequencing knowledge; the controller decides when it steps.
module johnson_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      if (dir) r_q <= {~r_q[0], r_q[WIDTH-1:1]};
      else     r_q <= {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Runs a Johnson counter for a commanded number of full periods with pause/abort.
//   state    | meaning
//   ST_IDLE  | waiting for a command, cmd_ready high
//   ST_RUN   | stepping q once per cycle unless paused or aborted
//   ST_PAUSE | q, phase and remaining held until pause drops
//   ST_DONE  | one-cycle done pulse, then back to idle
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [CNT_W-1:0]            cmd_cycles,
  input  logic                        cmd_dir,
  input  logic                        pause,
  input  logic                        abort,
  output logic [WIDTH-1:0]            q,
  output logic [PHASE_W(WIDTH)-1:0]   phase,
  output logic [CNT_W-1:0]            remaining,
  output logic                        busy,
  output logic                        done
);

  localparam int PW = PHASE_W(WIDTH);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * WIDTH - 1);

  state_t           r_state;
  logic [PW-1:0]    r_phase;
  logic [CNT_W-1:0] r_remaining;
  logic             r_dir;

  logic w_accept;
  logic w_active;
  logic w_step;
  logic w_clr;

  assign w_accept = (r_state == ST_IDLE) && cmd_valid;
  assign w_active = (r_state == ST_RUN) || (r_state == ST_PAUSE);
  assign w_step   = (r_state == ST_RUN) && !abort && !pause;
  assign w_clr    = w_accept || (w_active && abort);

  johnson_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (w_step),
    .clr     (w_clr),
    .dir     (r_dir),
    .q       (q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_remaining <= '0;
      r_dir       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_phase     <= '0;
            r_remaining <= cmd_cycles;
            r_dir       <= cmd_dir;
            r_state     <= (cmd_cycles == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_phase     <= '0;
            r_remaining <= '0;
            r_state     <= ST_IDLE;
          end else if (pause) begin
            r_state <= ST_PAUSE;
          end else if (r_phase == PH_LAST) begin
            // Period boundary: retire one period, finish on the last one.
            r_phase <= '0;
            if (r_remaining != '0) r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining <= CNT_W'(1)) r_state <= ST_DONE;
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (abort) begin
            r_phase     <= '0;
            r_remaining <= '0;
            r_state     <= ST_IDLE;
          end else if (!pause) begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = w_active;
  assign done      = (r_state == ST_DONE);
  assign phase     = r_phase;
  assign remaining = r_remaining;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench: the driver queues expected per-step outputs from an arithmetic
// Johnson model, a monitor pops and compares whenever q/phase move or done pulses.
module tb_johnson_seq_ctrl;

  localparam int W   = 4;
  localparam int CW  = 8;
  localparam int PW  = $clog2(2 * W);
  localparam int PER = 2 * W;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_cycles = '0;
  logic          cmd_dir = 1'b0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  q;
  logic [PW-1:0] phase;
  logic [CW-1:0] remaining;
  logic          busy;
  logic          done;

  johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_cycles (cmd_cycles),
    .cmd_dir    (cmd_dir),
    .pause      (pause),
    .abort      (abort),
    .q          (q),
    .phase      (phase),
    .remaining  (remaining),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int q;
    int phase;
    int rem;
    int done;
  } exp_t;

  exp_t sb[$];

  // After k steps in a period of 2W: first W steps fill ones, next W fill zeros.
  function automatic int model_q(int k, bit d);
    int m;
    int v;
    bit on;
    m = k % PER;
    v = 0;
    for (int i = 0; i < W; i++) begin
      on = (m <= W) ? (i < m) : (i >= m - W);
      if (on) v = v | (1 << (d ? (W - 1 - i) : i));
    end
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  initial begin : monitor
    int   pq;
    int   pph;
    exp_t e;
    pq  = 0;
    pph = 0;
    forever begin
      @(negedge clk);
      if (reset_n && (done || (busy && (int'(q) != pq || int'(phase) != pph)))) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: q=%b phase=%0d done=%0d with nothing expected", q, phase, done);
        end else begin
          e = sb.pop_front();
          check("mon_q", int'(q), e.q);
          check("mon_phase", int'(phase), e.phase);
          check("mon_remaining", int'(remaining), e.rem);
          check("mon_done", int'(done), e.done);
        end
      end
      pq  = int'(q);
      pph = int'(phase);
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_q"}, int'(q), 0);
    check({tag, "_phase"}, int'(phase), 0);
    check({tag, "_remaining"}, int'(remaining), 0);
    check({tag, "_ready"}, int'(cmd_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // mode: 0 complete, 1 abort while running, 2 abort while paused, 3 reset mid-run.
  task automatic run_cmd(input int n, input bit d, input int pause_at, input int pause_len,
                         input int mode, input int stop_at);
    int   s;
    int   stop;
    int   steps;
    bit   paused;
    exp_t e;
    s      = n * PER;
    stop   = (mode == 0) ? s : stop_at;
    steps  = 0;
    paused = 1'b0;
    for (int k = 1; k <= stop; k++) begin
      e.q     = model_q(k, d);
      e.phase = k % PER;
      e.rem   = n - k / PER;
      e.done  = (mode == 0 && k == s) ? 1 : 0;
      sb.push_back(e);
    end
    if (mode == 0 && n == 0) begin
      e.q = 0; e.phase = 0; e.rem = 0; e.done = 1;
      sb.push_back(e);
    end

    @(negedge clk);
    check("ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_cycles = CW'(n);
    cmd_dir    = d;
    pause      = 1'b0;
    abort      = 1'b0;
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_cycles = CW'($urandom);
    cmd_dir    = 1'($urandom);

    while (steps < stop) begin
      if (pause_len > 0 && !paused && steps == pause_at) begin
        paused = 1'b1;
        pause  = 1'b1;
        repeat (pause_len) @(negedge clk);
        check("paused_q", int'(q), model_q(steps, d));
        check("paused_phase", int'(phase), steps % PER);
        pause = 1'b0;
        @(negedge clk);
      end
      @(negedge clk);
      steps++;
    end

    case (mode)
      0: begin
        check("done_pulse", int'(done), 1);
        check("done_q", int'(q), 0);
        abort = 1'($urandom);
        pause = 1'($urandom);
        @(negedge clk);
        abort = 1'b0;
        pause = 1'b0;
        check_idle("after_done");
      end
      1, 2: begin
        if (mode == 2) begin
          pause = 1'b1;
          @(negedge clk);
          check("pause_busy", int'(busy), 1);
          check("pause_hold_q", int'(q), model_q(stop, d));
        end else begin
          pause = 1'($urandom);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        pause = 1'b0;
        check_idle("after_abort");
      end
      default: begin
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_q", int'(q), 0);
        check("rst_mid_remaining", int'(remaining), 0);
        check("rst_mid_busy", int'(busy), 0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_idle("after_reset");
      end
    endcase
    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic idle_gap();
    int g;
    g = $urandom_range(0, 3);
    repeat (g) begin
      pause = 1'($urandom);
      abort = 1'($urandom);
      @(negedge clk);
      check("gap_ready", int'(cmd_ready), 1);
      check("gap_done", int'(done), 0);
    end
    pause = 1'b0;
    abort = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int n, s, pa, pl, mode, st;
    bit d;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_q", int'(q), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_remaining", int'(remaining), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    run_cmd(1, 1'b0, -1, 0, 0, 0);
    run_cmd(2, 1'b1, -1, 0, 0, 0);
    run_cmd(0, 1'b0, -1, 0, 0, 0);
    run_cmd(3, 1'b0, 3, 5, 0, 0);
    run_cmd(2, 1'b0, -1, 0, 1, 5);
    run_cmd(2, 1'b1, -1, 0, 3, 6);
    run_cmd(1, 1'b1, -1, 0, 2, 3);
    run_cmd(255, 1'b1, 100, 2, 0, 0);

    for (int r = 0; r < 40; r++) begin
      idle_gap();
      n    = $urandom_range(0, 6);
      d    = 1'($urandom);
      s    = n * PER;
      pa   = $urandom_range(0, s);
      pl   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4);
      mode = (s == 0) ? 0 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      st   = (s == 0) ? 0 : $urandom_range(0, s - 1);
      run_cmd(n, d, pa, pl, mode, st);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
